// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-count debounce FSM,
// press/release/long-hold strobes and a wrapping press counter.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 100_000_000,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic       sysClk,
  input  logic       rst,
  input  logic       btnIn,
  output logic       btnLevel,
  output logic       pressPulse,
  output logic       releasePulse,
  output logic       holdPulse,
  output logic [7:0] pressCount
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    RELEASE_PENDING
  } state_t;

  state_t             state;
  logic               s1;
  logic               s2;
  logic [DB_W-1:0]    db_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               db_done;
  logic               release_accept;

  always_comb begin
    db_done        = 1'b0;
    release_accept = 1'b0;
    db_done        = (s2 != btnLevel) && (db_cnt == DB_LAST);
    release_accept = (state == RELEASE_PENDING) && !s2 && db_done;
  end

  always_ff @(posedge sysClk) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      state        <= RELEASED;
      db_cnt       <= '0;
      hold_cnt     <= '0;
      btnLevel     <= 1'b0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      holdPulse    <= 1'b0;
      pressCount   <= '0;
    end else begin
      s1           <= btnIn ^ ACTIVE_LOW;
      s2           <= s1;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      holdPulse    <= 1'b0;

      // The counter runs on any mismatch with the accepted level; the FSM
      // only tracks which direction is pending and performs the flip.
      if ((s2 == btnLevel) || db_done) db_cnt <= '0;
      else                             db_cnt <= db_cnt + 1'b1;

      case (state)
        RELEASED: begin
          if (s2) state <= PRESS_PENDING;
        end
        PRESS_PENDING: begin
          if (!s2) begin
            state <= RELEASED;
          end else if (db_done) begin
            state      <= PRESSED;
            btnLevel   <= 1'b1;
            pressPulse <= 1'b1;
            pressCount <= pressCount + 8'd1;
          end
        end
        PRESSED: begin
          if (!s2) state <= RELEASE_PENDING;
        end
        RELEASE_PENDING: begin
          if (s2) begin
            state <= PRESSED;
          end else if (db_done) begin
            state        <= RELEASED;
            btnLevel     <= 1'b0;
            releasePulse <= 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase

      // Release accepted on the firing edge suppresses the hold strobe.
      if (!btnLevel) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
        if ((hold_cnt == HOLD_PRE) && !release_accept) holdPulse <= 1'b1;
      end
    end
  end

endmodule
